mac_dot_sequencer: RTL and testbench

- Upstream feeder and result collector for the single-precision MAC.
- Buffers incoming (data, weight) operand pairs in a small FIFO and issues one pair per cycle to the MAC as valid-tagged scalars.
- Clears the MAC accumulator before each dot product of VEC_LEN elements, waits out the MAC pipeline, then captures the accumulated result.
- Presents the result on a valid/ready output toward the next layer stage.

---
 rtl/mac_dot_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_mac_dot_sequencer.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: buffers (data, weight) operand pairs, streams them one per cycle to the
// single-precision MAC, brackets each VEC_LEN-element dot product with an accumulator clear,
// waits out the MAC pipeline and hands the captured sum to the next stage over valid/ready.
// No arithmetic happens here; all values pass through bit-exact.

module mac_dot_sequencer #(
    parameter int unsigned VEC_LEN     = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned MAC_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [31:0] in_weight,
    output logic [31:0] mac_data_value,
    output logic        mac_data_valid,
    output logic [31:0] mac_weight_value,
    output logic        mac_weight_valid,
    output logic        mac_clear,
    input  logic [31:0] mac_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_value
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ElemW = $clog2(VEC_LEN + 1);
    localparam int unsigned LatW  = $clog2(MAC_LATENCY + 1);

    localparam logic [CntW-1:0]  FifoFull = CntW'(FIFO_DEPTH);
    localparam logic [ElemW-1:0] LastElem = ElemW'(VEC_LEN - 1);
    localparam logic [LatW-1:0]  LatDone  = LatW'(MAC_LATENCY);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StDrain,
        StHold
    } state_e;

    // ------------------------------------------------------------------
    // Operand-pair FIFO
    // ------------------------------------------------------------------
    logic [63:0]     fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] fifo_wr_ptr_q;
    logic [PtrW-1:0] fifo_rd_ptr_q;
    logic [CntW-1:0] fifo_cnt_q;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            pop;
    logic [63:0]     fifo_rd_data;

    assign fifo_empty   = (fifo_cnt_q == '0);
    assign fifo_full    = (fifo_cnt_q == FifoFull);
    assign in_ready     = ~fifo_full;
    assign push         = in_valid & ~fifo_full;
    assign fifo_rd_data = fifo_mem_q[fifo_rd_ptr_q];

    // Storage: no reset needed, the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[fifo_wr_ptr_q] <= {in_data, in_weight};
        end
    end

    // Pointers wrap naturally since FIFO_DEPTH is a power of two; push+pop keeps the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wr_ptr_q <= '0;
            fifo_rd_ptr_q <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            if (push) begin
                fifo_wr_ptr_q <= fifo_wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                fifo_rd_ptr_q <= fifo_rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CntW'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CntW'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [ElemW-1:0] elem_cnt_q, elem_cnt_d;
    logic [LatW-1:0]  lat_cnt_q, lat_cnt_d;
    logic             mac_valid_q, mac_valid_d;
    logic [31:0]      mac_data_q, mac_data_d;
    logic [31:0]      mac_weight_q, mac_weight_d;
    logic             mac_clear_q, mac_clear_d;
    logic             res_valid_q, res_valid_d;
    logic [31:0]      res_value_q, res_value_d;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counters, FIFO pop and next values of every registered output.
    always_comb begin
        state_d      = state_q;
        elem_cnt_d   = elem_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        mac_valid_d  = 1'b0;
        mac_data_d   = mac_data_q;
        mac_weight_d = mac_weight_q;
        res_valid_d  = res_valid_q;
        res_value_d  = res_value_q;
        pop          = 1'b0;

        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                elem_cnt_d = '0;
                state_d    = StStream;
            end
            StStream: begin
                // An empty FIFO is a bubble: valids stay low and the MAC holds its sum.
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    mac_valid_d  = 1'b1;
                    mac_data_d   = fifo_rd_data[63:32];
                    mac_weight_d = fifo_rd_data[31:0];
                    elem_cnt_d   = elem_cnt_q + ElemW'(1);
                    if (elem_cnt_q == LastElem) begin
                        lat_cnt_d = '0;
                        state_d   = StDrain;
                    end
                end
            end
            StDrain: begin
                // lat_cnt_q == k in the k-th cycle after the last pair reached the MAC.
                if (lat_cnt_q == LatDone) begin
                    res_value_d = mac_out;
                    res_valid_d = 1'b1;
                    state_d     = StHold;
                end else begin
                    lat_cnt_d = lat_cnt_q + LatW'(1);
                end
            end
            StHold: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = fifo_empty ? StIdle : StClear;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered so the pulse lines up exactly with the CLEAR cycle.
        mac_clear_d = (state_d == StClear);
    end

    // Counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            elem_cnt_q   <= '0;
            lat_cnt_q    <= '0;
            mac_valid_q  <= 1'b0;
            mac_data_q   <= '0;
            mac_weight_q <= '0;
            mac_clear_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            res_value_q  <= '0;
        end else begin
            elem_cnt_q   <= elem_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            mac_valid_q  <= mac_valid_d;
            mac_data_q   <= mac_data_d;
            mac_weight_q <= mac_weight_d;
            mac_clear_q  <= mac_clear_d;
            res_valid_q  <= res_valid_d;
            res_value_q  <= res_value_d;
        end
    end

    assign mac_data_value   = mac_data_q;
    assign mac_weight_value = mac_weight_q;
    assign mac_data_valid   = mac_valid_q;
    assign mac_weight_valid = mac_valid_q;
    assign mac_clear        = mac_clear_q;
    assign res_valid        = res_valid_q;
    assign res_value        = res_value_q;

    // A clear must never coincide with a pair, or that pair would be lost from the sum.
    a_clear_excl: assert property (@(posedge clk) disable iff (rst)
        !(mac_clear && mac_data_valid));

    // The result must not change while the consumer is stalling.
    a_res_stable: assert property (@(posedge clk) disable iff (rst)
        (res_valid && !res_ready) |=> (res_valid && $stable(res_value)));

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer: two instances (VEC_LEN=4 and VEC_LEN=1) each driven against a
// small behavioural MAC with a two-cycle input-to-output latency.

module tb_mac_dot_sequencer;

    localparam logic [31:0] F0P5 = 32'h3F00_0000;
    localparam logic [31:0] F1   = 32'h3F80_0000;
    localparam logic [31:0] F2   = 32'h4000_0000;
    localparam logic [31:0] F3   = 32'h4040_0000;
    localparam logic [31:0] F4   = 32'h4080_0000;
    localparam logic [31:0] F5   = 32'h40A0_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: VEC_LEN=4
    logic        in_valid_a, in_ready_a, res_ready_a, res_valid_a;
    logic [31:0] in_data_a, in_weight_a, res_value_a, mac_out_a;
    logic [31:0] mac_data_value_a, mac_weight_value_a;
    logic        mac_data_valid_a, mac_weight_valid_a, mac_clear_a;

    // Instance B: VEC_LEN=1
    logic        in_valid_b, in_ready_b, res_ready_b, res_valid_b;
    logic [31:0] in_data_b, in_weight_b, res_value_b, mac_out_b;
    logic [31:0] mac_data_value_b, mac_weight_value_b;
    logic        mac_data_valid_b, mac_weight_valid_b, mac_clear_b;

    mac_dot_sequencer #(.VEC_LEN(4), .FIFO_DEPTH(4), .MAC_LATENCY(2)) u_dut_a (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid_a),
        .in_ready         (in_ready_a),
        .in_data          (in_data_a),
        .in_weight        (in_weight_a),
        .mac_data_value   (mac_data_value_a),
        .mac_data_valid   (mac_data_valid_a),
        .mac_weight_value (mac_weight_value_a),
        .mac_weight_valid (mac_weight_valid_a),
        .mac_clear        (mac_clear_a),
        .mac_out          (mac_out_a),
        .res_valid        (res_valid_a),
        .res_ready        (res_ready_a),
        .res_value        (res_value_a)
    );

    mac_dot_sequencer #(.VEC_LEN(1), .FIFO_DEPTH(4), .MAC_LATENCY(2)) u_dut_b (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid_b),
        .in_ready         (in_ready_b),
        .in_data          (in_data_b),
        .in_weight        (in_weight_b),
        .mac_data_value   (mac_data_value_b),
        .mac_data_valid   (mac_data_valid_b),
        .mac_weight_value (mac_weight_value_b),
        .mac_weight_valid (mac_weight_valid_b),
        .mac_clear        (mac_clear_b),
        .mac_out          (mac_out_b),
        .res_valid        (res_valid_b),
        .res_ready        (res_ready_b),
        .res_value        (res_value_b)
    );

    // Single <-> double conversion, exact for the normal values used here.
    function automatic real sp2real(input logic [31:0] b);
        logic [10:0] e;
        if (b[30:0] == 31'd0) return 0.0;
        e = {3'b000, b[30:23]} + 11'd896;
        return $bitstoreal({b[31], e, b[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] real2sp(input real r);
        logic [63:0] d;
        logic [7:0]  e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        e = 8'(d[62:52] - 11'd896);
        return {d[63], e, d[51:29]};
    endfunction

    // Behavioural MACs: accumulator register plus one output stage (two-cycle latency).
    logic [31:0] acc_a = '0, acc_b = '0;
    always @(posedge clk) begin
        if (mac_clear_a) acc_a <= 32'd0;
        else if (mac_data_valid_a)
            acc_a <= real2sp(sp2real(acc_a) +
                             sp2real(mac_data_value_a) * sp2real(mac_weight_value_a));
        mac_out_a <= acc_a;
        if (mac_clear_b) acc_b <= 32'd0;
        else if (mac_data_valid_b)
            acc_b <= real2sp(sp2real(acc_b) +
                             sp2real(mac_data_value_b) * sp2real(mac_weight_value_b));
        mac_out_b <= acc_b;
    end

    int unsigned vec_n = 0, bad_n = 0;
    int unsigned cyc = 0;
    int unsigned clr_n = 0, pair_n = 0, res_n = 0, resv_n = 0, viol_n = 0;
    int unsigned first_v = 0, last_v = 0, first_res = 0;
    int unsigned clr_t [8];
    logic [31:0] res_log [8];
    int unsigned clr_b_n = 0, pair_b_n = 0, resv_b_n = 0, viol_b_n = 0;

    // Observers sample just after the falling edge, where inputs and outputs are settled.
    always @(negedge clk) begin
        #1;
        cyc++;
        if (!rst) begin
            if (mac_clear_a) begin
                if (clr_n < 8) clr_t[clr_n] = cyc;
                clr_n++;
            end
            if (mac_data_valid_a) begin
                if (pair_n == 0) first_v = cyc;
                last_v = cyc;
                pair_n++;
            end
            if ((mac_data_valid_a !== mac_weight_valid_a) || (mac_clear_a && mac_data_valid_a))
                viol_n++;
            if (res_valid_a) begin
                if (resv_n == 0) first_res = cyc;
                resv_n++;
                if (res_ready_a) begin
                    if (res_n < 8) res_log[res_n] = res_value_a;
                    res_n++;
                end
            end
            if (mac_clear_b) clr_b_n++;
            if (mac_data_valid_b) pair_b_n++;
            if (res_valid_b) resv_b_n++;
            if ((mac_data_valid_b !== mac_weight_valid_b) || (mac_clear_b && mac_data_valid_b))
                viol_b_n++;
        end
    end

    task automatic clear_mon();
        clr_n = 0; pair_n = 0; res_n = 0; resv_n = 0; viol_n = 0;
        clr_b_n = 0; pair_b_n = 0; resv_b_n = 0; viol_b_n = 0;
    endtask

    task automatic push_a(input logic [31:0] d, input logic [31:0] w, output logic ok);
        ok = 1'b0;
        in_valid_a = 1'b1; in_data_a = d; in_weight_a = w;
        for (int i = 0; i < 50; i++) begin
            if (in_ready_a) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        in_valid_a = 1'b0;
    endtask

    task automatic wait_res(input bit use_b, input int unsigned limit,
                            output logic got, output logic [31:0] val);
        got = 1'b0; val = '0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!use_b && res_valid_a) begin got = 1'b1; val = res_value_a; break; end
            if (use_b && res_valid_b) begin got = 1'b1; val = res_value_b; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vec_n++;
        if ({in_ready_a, mac_data_valid_a, mac_weight_valid_a, mac_clear_a, res_valid_a}
            !== 5'b10000) begin
            bad_n++;
            $display("FAIL reset_ctrl_a: got %b want 10000", {in_ready_a, mac_data_valid_a,
                     mac_weight_valid_a, mac_clear_a, res_valid_a});
        end
        vec_n++;
        if ({mac_data_value_a, mac_weight_value_a, res_value_a} !== 96'd0) begin
            bad_n++;
            $display("FAIL reset_values_a: got %h %h %h want 0", mac_data_value_a,
                     mac_weight_value_a, res_value_a);
        end
        vec_n++;
        if ({in_ready_b, mac_data_valid_b, mac_clear_b, res_valid_b, res_value_b}
            !== {4'b1000, 32'd0}) begin
            bad_n++;
            $display("FAIL reset_b: got %b %b %b %b %h want 1 0 0 0 0", in_ready_b,
                     mac_data_valid_b, mac_clear_b, res_valid_b, res_value_b);
        end
        rst = 1'b0;
        clear_mon();
        @(negedge clk);
    endtask

    task automatic test_single_vector();
        logic ok, got;
        logic [31:0] val;
        int unsigned pf = 0;
        clear_mon();
        res_ready_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_a(F5, F5, ok);
            if (!ok) pf++;
        end
        wait_res(1'b0, 40, got, val);
        repeat (4) @(negedge clk);
        vec_n++; if (pf != 0) begin bad_n++; $display("FAIL single_push: got %0d stalls want 0", pf); end
        vec_n++; if (got !== 1'b1) begin bad_n++; $display("FAIL single_timeout: got %b want 1", got); end
        vec_n++;
        if (val !== 32'h42C8_0000) begin
            bad_n++; $display("FAIL single_value: got %h want 42c80000", val);
        end
        vec_n++; if (clr_n != 1) begin bad_n++; $display("FAIL single_clears: got %0d want 1", clr_n); end
        vec_n++; if (pair_n != 4) begin bad_n++; $display("FAIL single_pairs: got %0d want 4", pair_n); end
        vec_n++;
        if (last_v - first_v != 3) begin
            bad_n++; $display("FAIL single_consecutive: got span %0d want 3", last_v - first_v);
        end
        vec_n++;
        if (first_v - clr_t[0] != 2) begin
            bad_n++; $display("FAIL single_clear_to_pair: got %0d want 2", first_v - clr_t[0]);
        end
        vec_n++;
        if (first_res - clr_t[0] != 8) begin
            bad_n++; $display("FAIL single_latency: got %0d want 8", first_res - clr_t[0]);
        end
        vec_n++; if (resv_n != 1) begin bad_n++; $display("FAIL single_res_cycles: got %0d want 1", resv_n); end
        vec_n++; if (viol_n != 0) begin bad_n++; $display("FAIL single_valid_rules: got %0d want 0", viol_n); end
    endtask

    task automatic test_bubbles();
        logic ok, got;
        logic [31:0] val;
        logic [31:0] dv [4];
        int unsigned pf = 0;
        dv[0] = F1; dv[1] = F2; dv[2] = F3; dv[3] = F4;
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            push_a(dv[i], F1, ok);
            if (!ok) pf++;
            @(negedge clk);
        end
        wait_res(1'b0, 40, got, val);
        repeat (4) @(negedge clk);
        vec_n++; if (pf != 0) begin bad_n++; $display("FAIL bubble_push: got %0d stalls want 0", pf); end
        vec_n++;
        if (got !== 1'b1 || val !== 32'h4120_0000) begin
            bad_n++; $display("FAIL bubble_value: got %b/%h want 1/41200000", got, val);
        end
        vec_n++; if (pair_n != 4) begin bad_n++; $display("FAIL bubble_pairs: got %0d want 4", pair_n); end
        vec_n++;
        if (last_v - first_v != 4) begin
            bad_n++; $display("FAIL bubble_span: got %0d want 4", last_v - first_v);
        end
        vec_n++; if (viol_n != 0) begin bad_n++; $display("FAIL bubble_valid_rules: got %0d want 0", viol_n); end
    endtask

    task automatic test_hold();
        logic ok, got;
        logic [31:0] val;
        logic [31:0] dv [4];
        int unsigned pf = 0;
        dv[0] = F1; dv[1] = F2; dv[2] = F3; dv[3] = F4;
        clear_mon();
        res_ready_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_a(F5, F5, ok);
            if (!ok) pf++;
        end
        wait_res(1'b0, 40, got, val);
        vec_n++; if (got !== 1'b1) begin bad_n++; $display("FAIL hold_timeout: got %b want 1", got); end
        for (int i = 0; i < 10; i++) begin
            in_valid_a = (i < 4);
            in_data_a  = dv[i % 4];
            in_weight_a = F2;
            if (i == 4 || i == 9) begin
                vec_n++;
                if (in_ready_a !== 1'b0) begin
                    bad_n++; $display("FAIL hold_fifo_full[%0d]: got %b want 0", i, in_ready_a);
                end
            end
            vec_n++;
            if (res_valid_a !== 1'b1 || res_value_a !== 32'h42C8_0000) begin
                bad_n++;
                $display("FAIL hold_stable[%0d]: got %b/%h want 1/42c80000", i, res_valid_a,
                         res_value_a);
            end
            @(negedge clk);
        end
        in_valid_a = 1'b0;
        clear_mon();
        res_ready_a = 1'b1;
        wait_res(1'b0, 40, got, val);
        repeat (3) @(negedge clk);
        vec_n++; if (pf != 0) begin bad_n++; $display("FAIL hold_push: got %0d stalls want 0", pf); end
        vec_n++;
        if (got !== 1'b1 || val !== 32'h41A0_0000) begin
            bad_n++; $display("FAIL hold_second: got %b/%h want 1/41a00000", got, val);
        end
        vec_n++;
        if (res_n != 2 || res_log[0] !== 32'h42C8_0000) begin
            bad_n++; $display("FAIL hold_accept: got %0d/%h want 2/42c80000", res_n, res_log[0]);
        end
        vec_n++;
        if (clr_n != 1 || clr_t[0] - first_res != 1) begin
            bad_n++;
            $display("FAIL hold_clear_after_handshake: got %0d clears, gap %0d want 1, 1",
                     clr_n, clr_t[0] - first_res);
        end
    endtask

    task automatic test_back_to_back();
        logic ok;
        logic [31:0] dv [4];
        int unsigned pf = 0;
        dv[0] = F1; dv[1] = F2; dv[2] = F3; dv[3] = F4;
        clear_mon();
        res_ready_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) push_a(F5, F5, ok);
            else push_a(dv[i - 4], F3, ok);
            if (!ok) pf++;
        end
        for (int i = 0; i < 80 && res_n < 2; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        vec_n++; if (pf != 0) begin bad_n++; $display("FAIL b2b_push: got %0d timeouts want 0", pf); end
        vec_n++; if (res_n != 2) begin bad_n++; $display("FAIL b2b_results: got %0d want 2", res_n); end
        vec_n++;
        if (res_log[0] !== 32'h42C8_0000 || res_log[1] !== 32'h41F0_0000) begin
            bad_n++;
            $display("FAIL b2b_values: got %h %h want 42c80000 41f00000", res_log[0], res_log[1]);
        end
        vec_n++;
        if (clr_n != 2 || clr_t[1] - clr_t[0] != 9) begin
            bad_n++;
            $display("FAIL b2b_spacing: got %0d clears, gap %0d want 2, 9", clr_n,
                     clr_t[1] - clr_t[0]);
        end
        vec_n++; if (pair_n != 8) begin bad_n++; $display("FAIL b2b_pairs: got %0d want 8", pair_n); end
        vec_n++; if (viol_n != 0) begin bad_n++; $display("FAIL b2b_valid_rules: got %0d want 0", viol_n); end
    endtask

    task automatic test_mid_reset();
        logic ok, got;
        logic [31:0] val;
        int unsigned pf = 0;
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            push_a(F5, F5, ok);
            if (!ok) pf++;
        end
        for (int i = 0; i < 30 && pair_n < 2; i++) @(negedge clk);
        vec_n++; if (pair_n != 2) begin bad_n++; $display("FAIL rst_issue: got %0d pairs want 2", pair_n); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vec_n++;
        if ({in_ready_a, mac_data_valid_a, mac_weight_valid_a, mac_clear_a, res_valid_a}
            !== 5'b10000) begin
            bad_n++;
            $display("FAIL rst_ctrl: got %b want 10000", {in_ready_a, mac_data_valid_a,
                     mac_weight_valid_a, mac_clear_a, res_valid_a});
        end
        vec_n++;
        if ({mac_data_value_a, mac_weight_value_a, res_value_a} !== 96'd0) begin
            bad_n++;
            $display("FAIL rst_values: got %h %h %h want 0", mac_data_value_a,
                     mac_weight_value_a, res_value_a);
        end
        clear_mon();
        repeat (15) @(negedge clk);
        vec_n++;
        if (resv_n != 0 || clr_n != 0 || pair_n != 0) begin
            bad_n++;
            $display("FAIL rst_abandon: got res %0d clr %0d pairs %0d want 0 0 0", resv_n,
                     clr_n, pair_n);
        end
        for (int i = 0; i < 4; i++) begin
            push_a(F2, F0P5, ok);
            if (!ok) pf++;
        end
        wait_res(1'b0, 40, got, val);
        vec_n++; if (pf != 0) begin bad_n++; $display("FAIL rst_push: got %0d stalls want 0", pf); end
        vec_n++;
        if (got !== 1'b1 || val !== 32'h4080_0000) begin
            bad_n++; $display("FAIL rst_fresh: got %b/%h want 1/40800000", got, val);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_vec_len_one();
        logic got;
        logic [31:0] val;
        clear_mon();
        res_ready_b = 1'b1;
        in_valid_b = 1'b1; in_data_b = F3; in_weight_b = F2;
        @(negedge clk);
        in_valid_b = 1'b0;
        wait_res(1'b1, 30, got, val);
        repeat (3) @(negedge clk);
        vec_n++;
        if (got !== 1'b1 || val !== 32'h40C0_0000) begin
            bad_n++; $display("FAIL len1_value: got %b/%h want 1/40c00000", got, val);
        end
        vec_n++;
        if (clr_b_n != 1 || pair_b_n != 1 || resv_b_n != 1 || viol_b_n != 0) begin
            bad_n++;
            $display("FAIL len1_counts: got clr %0d pairs %0d res %0d viol %0d want 1 1 1 0",
                     clr_b_n, pair_b_n, resv_b_n, viol_b_n);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid_a = 1'b0; in_data_a = '0; in_weight_a = '0; res_ready_a = 1'b1;
        in_valid_b = 1'b0; in_data_b = '0; in_weight_b = '0; res_ready_b = 1'b1;
        test_reset();
        test_single_vector();
        test_bubbles();
        test_hold();
        test_back_to_back();
        test_mid_reset();
        test_vec_len_one();
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, bad_n);
        $finish;
    end

endmodule
